// File: rtl/wave_sched_pkg.sv
// Shared types and helpers for the wave weight scheduler.
// Constants, FSM state enum, weight slot struct, sign-magnitude conversion.
package wave_sched_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int VEC_LENGTH = 8;
  localparam int MAG_WIDTH  = DATA_WIDTH - 1;
  localparam int COL_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  typedef logic [MAG_WIDTH-1:0] mag_t;
  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] wvec_t;

  typedef struct packed {
    mag_t [VEC_LENGTH-1:0] mag;
    logic [VEC_LENGTH-1:0] sign;
    mag_t                  mask;
    logic                  load_accum;
    logic                  valid;
  } slot_t;

  // -2^(N-1) has no positive twin; clamp it to the largest magnitude.
  function automatic mag_t to_mag(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] a;
    a = w[DATA_WIDTH-1] ? -w : w;
    return a[DATA_WIDTH-1] ? {MAG_WIDTH{1'b1}} : a[MAG_WIDTH-1:0];
  endfunction

  function automatic slot_t convert(input wvec_t d, input logic la);
    slot_t s;
    s = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      s.mag[j]  = to_mag(d[j]);
      s.sign[j] = d[j][DATA_WIDTH-1];
      s.mask    = s.mask | s.mag[j];
    end
    s.load_accum = la;
    s.valid      = 1'b1;
    return s;
  endfunction
endpackage

// File: rtl/wave_weight_scheduler_if.sv
// Weight vector handshake between producer and scheduler.
// Ports: w_data, w_load_accum, w_valid (producer), w_ready (scheduler).
interface wave_weight_scheduler_if;
  import wave_sched_pkg::*;

  wvec_t w_data;
  logic  w_load_accum;
  logic  w_valid;
  logic  w_ready;

  modport master (
    output w_data, w_load_accum, w_valid,
    input  w_ready
  );

  modport slave (
    input  w_data, w_load_accum, w_valid,
    output w_ready
  );
endinterface

// File: rtl/wave_weight_scheduler_column_priority_select.sv
// Highest-set-bit encoder over a magnitude column mask.
// In: mask. Out: idx (top bit), any (mask != 0), is_last (one-hot).
module column_priority_select
  import wave_sched_pkg::*;
(
  input  mag_t                 mask,
  output logic [COL_WIDTH-1:0] idx,
  output logic                 any,
  output logic                 is_last
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < MAG_WIDTH; i++) begin
      if (mask[i]) idx = COL_WIDTH'(i);
    end
  end

  assign any     = |mask;
  assign is_last = any && ((mask & (mask - mag_t'(1))) == '0);
endmodule

// File: rtl/wave_weight_scheduler.sv
// Bit-serial weight column scheduler feeding the wave MAC.
// Ports: clk, reset (async low), bus (slave handshake), MAC drive outputs, act_adv, busy.
module wave_weight_scheduler
  import wave_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  wave_weight_scheduler_if.slave bus,
  output logic [VEC_LENGTH-1:0] sign,
  output logic [VEC_LENGTH-1:0] w_bit,
  output logic [COL_WIDTH-1:0]  column_idx,
  output logic                  en,
  output logic                  load_accum,
  output logic                  act_adv,
  output logic                  busy
);
  state_e state_q, state_d;
  slot_t  act_q, act_d, pend_q, pend_d, in_slot;
  logic   first_q, first_d, ready_q, ready_d;
  logic [VEC_LENGTH-1:0] sign_q, sign_d, w_bit_q, w_bit_d;
  logic [COL_WIDTH-1:0]  column_idx_q, column_idx_d;
  logic en_q, en_d, load_accum_q, load_accum_d;
  logic act_adv_q, act_adv_d;

  logic [COL_WIDTH-1:0] cur_idx, nx_idx;
  logic cur_any, cur_one, nx_any, nx_one;
  logic cur_last, accept, issue;
  logic cont, promote, take;
  mag_t rem;

  // act_q.mask still holds the column currently on the outputs.
  column_priority_select u_cur (
    .mask    (act_q.mask),
    .idx     (cur_idx),
    .any     (cur_any),
    .is_last (cur_one)
  );

  column_priority_select u_nx (
    .mask    (act_d.mask),
    .idx     (nx_idx),
    .any     (nx_any),
    .is_last (nx_one)
  );

  assign in_slot  = convert(bus.w_data, bus.w_load_accum);
  assign accept   = bus.w_valid && ready_q;
  assign cur_last = (state_q == ISSUE) && (cur_one || !cur_any);
  assign rem      = act_q.mask & ~(mag_t'(1) << cur_idx);

  assign cont    = (state_q == ISSUE) && act_q.valid && !cur_last;
  assign promote = !cont && pend_q.valid;
  assign take    = !cont && !pend_q.valid && accept;

  always_comb begin
    act_d   = act_q;
    pend_d  = pend_q;
    state_d = IDLE;
    first_d = 1'b0;
    issue   = 1'b0;
    unique case (1'b1)
      cont: begin
        act_d.mask = rem;
        issue      = 1'b1;
        if (accept) pend_d = in_slot;
      end
      promote: begin
        act_d   = pend_q;
        pend_d  = '0;
        issue   = 1'b1;
        first_d = 1'b1;
      end
      take: begin
        act_d   = in_slot;
        issue   = 1'b1;
        first_d = 1'b1;
      end
      default: begin
        act_d.valid = 1'b0;
        if (state_q == ISSUE) state_d = DRAIN;
      end
    endcase
    if (issue) state_d = ISSUE;
  end

  // MAC psum register lags one cycle, so load rides on the cycle after
  // a vector's first column.
  always_comb begin
    sign_d       = '0;
    w_bit_d      = '0;
    column_idx_d = '0;
    en_d         = 1'b0;
    act_adv_d    = 1'b0;
    load_accum_d = first_q && act_q.load_accum;
    ready_d      = !pend_d.valid;
    if (issue) begin
      sign_d = act_d.sign;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        w_bit_d[j] = act_d.mag[j][nx_idx];
      end
      column_idx_d = nx_idx;
      en_d         = 1'b1;
      act_adv_d    = nx_one || !nx_any;
    end else if (state_d == DRAIN) begin
      en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      first_q      <= 1'b0;
      ready_q      <= 1'b0;
      sign_q       <= '0;
      w_bit_q      <= '0;
      column_idx_q <= '0;
      en_q         <= 1'b0;
      load_accum_q <= 1'b0;
      act_adv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      first_q      <= first_d;
      ready_q      <= ready_d;
      sign_q       <= sign_d;
      w_bit_q      <= w_bit_d;
      column_idx_q <= column_idx_d;
      en_q         <= en_d;
      load_accum_q <= load_accum_d;
      act_adv_q    <= act_adv_d;
    end
  end

  assign bus.w_ready = ready_q;
  assign sign        = sign_q;
  assign w_bit       = w_bit_q;
  assign column_idx  = column_idx_q;
  assign en          = en_q;
  assign load_accum  = load_accum_q;
  assign act_adv     = act_adv_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_wave_weight_scheduler.sv
// Directed bench for wave_weight_scheduler.
// Packs outputs {en,la,adv,busy,rdy,col,w_bit,sign} and compares per cycle.
module tb_wave_weight_scheduler;
  import wave_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [VEC_LENGTH-1:0] sign, w_bit;
  logic [COL_WIDTH-1:0] column_idx;
  logic en, load_accum, act_adv, busy;
  logic [23:0] obs;
  int passed = 0;
  int total = 0;

  wave_weight_scheduler_if bus ();

  wave_weight_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sign       (sign),
    .w_bit      (w_bit),
    .column_idx (column_idx),
    .en         (en),
    .load_accum (load_accum),
    .act_adv    (act_adv),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign obs = {en, load_accum, act_adv, busy, bus.w_ready,
                column_idx, w_bit, sign};

  function automatic logic [23:0] ex(
    logic e, logic la, logic adv, logic bz, logic rdy,
    logic [2:0] col, logic [7:0] wb, logic [7:0] sg);
    return {e, la, adv, bz, rdy, col, wb, sg};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic wvec_t fill(logic [7:0] v);
    wvec_t d;
    for (int j = 0; j < VEC_LENGTH; j++) d[j] = v;
    return d;
  endfunction

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) cyc();
    total++;
    if (obs !== 24'h0)
      $display("FAIL reset_held got %h want %h", obs, 24'h0);
    else passed++;
    reset = 1'b1;
    cyc();
    total++;
    if (obs !== ex(0,0,0,0,1,0,8'h00,8'h00))
      $display("FAIL reset_rel got %h want %h", obs,
               ex(0,0,0,0,1,0,8'h00,8'h00));
    else passed++;
  endtask

  task automatic test_single();
    logic [23:0] e [3];
    e[0] = ex(1,0,1,1,1,0,8'hFF,8'h00);
    e[1] = ex(1,1,0,1,1,0,8'h00,8'h00);
    e[2] = ex(0,0,0,0,1,0,8'h00,8'h00);
    bus.w_data = fill(8'd1);
    bus.w_load_accum = 1'b1;
    bus.w_valid = 1'b1;
    cyc();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== e[i])
        $display("FAIL single c%0d got %h want %h", i, obs, e[i]);
      else passed++;
      cyc();
    end
  endtask

  task automatic test_mixed();
    logic [2:0] ec [4];
    logic [7:0] eb [4];
    logic [23:0] e;
    ec[0] = 3'd6; ec[1] = 3'd2; ec[2] = 3'd1; ec[3] = 3'd0;
    eb[0] = 8'h80; eb[1] = 8'h01; eb[2] = 8'h02; eb[3] = 8'h03;
    bus.w_data = '0;
    bus.w_data[0] = 8'd5;
    bus.w_data[1] = 8'hFD;
    bus.w_data[7] = 8'd64;
    bus.w_load_accum = 1'b0;
    bus.w_valid = 1'b1;
    cyc();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = ex(1,0,(i == 3),1,1,ec[i],eb[i],8'h02);
      total++;
      if (obs !== e)
        $display("FAIL mixed c%0d got %h want %h", i, obs, e);
      else passed++;
      cyc();
    end
    e = ex(1,0,0,1,1,0,8'h00,8'h00);
    total++;
    if (obs !== e) $display("FAIL mixed_drain got %h want %h", obs, e);
    else passed++;
    cyc();
    e = ex(0,0,0,0,1,0,8'h00,8'h00);
    total++;
    if (obs !== e) $display("FAIL mixed_idle got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_neg128();
    logic [23:0] e;
    bus.w_data = '0;
    bus.w_data[3] = 8'h80;
    bus.w_load_accum = 1'b0;
    bus.w_valid = 1'b1;
    cyc();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      e = ex(1,0,(i == 6),1,1,3'(6 - i),8'h08,8'h08);
      total++;
      if (obs !== e)
        $display("FAIL neg128 c%0d got %h want %h", i, obs, e);
      else passed++;
      cyc();
    end
    e = ex(1,0,0,1,1,0,8'h00,8'h00);
    total++;
    if (obs !== e) $display("FAIL neg128_drain got %h want %h", obs, e);
    else passed++;
    cyc();
    e = ex(0,0,0,0,1,0,8'h00,8'h00);
    total++;
    if (obs !== e) $display("FAIL neg128_idle got %h want %h", obs, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] e [5];
    e[0] = ex(1,0,0,1,1,1,8'hFF,8'h00);
    e[1] = ex(1,0,1,1,0,0,8'hFF,8'h00);
    e[2] = ex(1,0,1,1,1,2,8'hFF,8'h00);
    e[3] = ex(1,1,0,1,1,0,8'h00,8'h00);
    e[4] = ex(0,0,0,0,1,0,8'h00,8'h00);
    bus.w_data = fill(8'd3);
    bus.w_load_accum = 1'b0;
    bus.w_valid = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== e[i])
        $display("FAIL b2b c%0d got %h want %h", i, obs, e[i]);
      else passed++;
      if (i == 0) begin
        bus.w_data = fill(8'd4);
        bus.w_load_accum = 1'b1;
      end else begin
        bus.w_valid = 1'b0;
      end
      cyc();
    end
  endtask

  task automatic test_zero();
    logic [23:0] e [3];
    e[0] = ex(1,0,1,1,1,0,8'h00,8'h00);
    e[1] = ex(1,0,0,1,1,0,8'h00,8'h00);
    e[2] = ex(0,0,0,0,1,0,8'h00,8'h00);
    bus.w_data = '0;
    bus.w_load_accum = 1'b0;
    bus.w_valid = 1'b1;
    cyc();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== e[i])
        $display("FAIL zero c%0d got %h want %h", i, obs, e[i]);
      else passed++;
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] e [3];
    logic [23:0] idle;
    e[0] = ex(1,0,0,1,1,4,8'h01,8'h00);
    e[1] = ex(1,1,0,1,1,3,8'h01,8'h00);
    e[2] = ex(1,0,0,1,1,2,8'h01,8'h00);
    idle = ex(0,0,0,0,1,0,8'h00,8'h00);
    bus.w_data = '0;
    bus.w_data[0] = 8'd31;
    bus.w_load_accum = 1'b1;
    bus.w_valid = 1'b1;
    cyc();
    bus.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== e[i])
        $display("FAIL rstmid c%0d got %h want %h", i, obs, e[i]);
      else passed++;
      if (i < 2) cyc();
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 24'h0)
      $display("FAIL rstmid_async got %h want %h", obs, 24'h0);
    else passed++;
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (obs !== idle)
        $display("FAIL rstmid_after c%0d got %h want %h", i, obs, idle);
      else passed++;
    end
  endtask

  initial begin
    bus.w_data = '0;
    bus.w_load_accum = 1'b0;
    bus.w_valid = 1'b0;
    test_reset();
    test_single();
    test_mixed();
    test_neg128();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
